mul_div_seq: RTL and testbench

- Iterative unsigned multiply/divide unit (MULTU/DIVU) that produces HI/LO for the MIPS datapath.
- It is the initiator side of the 32-bit ALU interface: it drives operand A, operand B and the 3-bit op select, and consumes the ALU's result, V and Z.
- All arithmetic is performed by the attached ALU, one operation per cycle.
- The block itself holds only registers, a counter, the FSM and the carry recovery.

---
 rtl/mul_div_seq_pkg.sv | 19 +
 rtl/mul_div_seq_carry.sv | 20 ++
 rtl/mul_div_seq.sv | 172 +++++++++++++++++
 tb/tb_mul_div_seq.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_div_seq_pkg.sv
// Shared constants and types for the iterative multiply/divide unit.
package mul_div_seq_pkg;

  // ALU select encodings understood by the attached 32-bit ALU
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b100;

  // Operation select on the op input
  localparam logic OP_MULTU = 1'b0;
  localparam logic OP_DIVU  = 1'b1;

  // Controller states
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } md_state_e;

endpackage

// File: rtl/mul_div_seq_carry.sv
// Recovers the carry-out (bit 32) of the ALU from the operand and result MSBs.
// For subtract the ALU computes a + ~b + 1, so b31 is inverted; carry = 1
// then means a >= b unsigned.
module md_carry (
  input  logic a31,
  input  logic b31,
  input  logic r31,
  input  logic sub,
  output logic carry
);

  logic b_eff;

  // Carry of the MSB full adder, reconstructed from its sum output
  always_comb begin
    b_eff = sub ? ~b31 : b31;
    carry = (a31 & b_eff) | ((a31 | b_eff) & ~r31);
  end

endmodule

// File: rtl/mul_div_seq.sv
// Iterative unsigned MULTU/DIVU producing HI/LO. All arithmetic is done by an
// external combinational ALU, one add (multiply) or subtract (divide) per cycle.
module mul_div_seq
  import mul_div_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITER  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_s,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_v,
  input  logic             alu_z,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(ITER);

  md_state_e        state_q, state_d;
  logic             op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;   // H (multiply) or R (divide)
  logic [WIDTH-1:0] lsr_q, lsr_d;   // L (multiply) or Q (divide)
  logic [WIDTH-1:0] opb_q, opb_d;   // M (multiply) or D (divide)
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] t_w;
  logic             carry_w;
  logic             last_w;
  logic             run_div_w;
  logic             unused_alu_flags;

  assign unused_alu_flags = alu_v ^ alu_z;

  assign t_w       = {acc_q[WIDTH-2:0], lsr_q[WIDTH-1]};
  assign last_w    = (cnt_q == CW'(ITER - 1));
  assign run_div_w = (state_q == S_RUN) && (op_q == OP_DIVU);

  md_carry u_carry (
    .a31   (alu_a[WIDTH-1]),
    .b31   (alu_b[WIDTH-1]),
    .r31   (alu_result[WIDTH-1]),
    .sub   (run_div_w),
    .carry (carry_w)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = (op == OP_DIVU && src_b == '0) ? S_DONE : S_RUN;
      S_RUN:  if (last_w) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: status flags and ALU drive
  always_comb begin
    busy  = (state_q != S_IDLE);
    done  = (state_q == S_DONE);
    alu_a = '0;
    alu_b = '0;
    alu_s = ALU_ADD;
    if (state_q == S_RUN) begin
      if (op_q == OP_MULTU) begin
        alu_a = acc_q;
        alu_b = lsr_q[0] ? opb_q : '0;
        alu_s = ALU_ADD;
      end else begin
        alu_a = t_w;
        alu_b = opb_q;
        alu_s = ALU_SUB;
      end
    end
  end

  // Datapath next values: operand latch, shift-add / restoring-divide step
  always_comb begin
    op_d  = op_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    lsr_d = lsr_q;
    opb_d = opb_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    dbz_d = dbz_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d  = op;
          cnt_d = '0;
          acc_d = '0;
          lsr_d = src_a;
          opb_d = src_b;
          dbz_d = 1'b0;
          if (op == OP_DIVU && src_b == '0) begin
            dbz_d = 1'b1;
            hi_d  = src_a;
            lo_d  = '1;
          end
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (op_q == OP_MULTU) begin
          acc_d = {carry_w, alu_result[WIDTH-1:1]};
          lsr_d = {alu_result[0], lsr_q[WIDTH-1:1]};
        end else if (acc_q[WIDTH-1] | carry_w) begin
          // 33-bit partial remainder {R[31], T} >= D: keep the difference
          acc_d = alu_result;
          lsr_d = {lsr_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = t_w;
          lsr_d = {lsr_q[WIDTH-2:0], 1'b0};
        end
        if (last_w) begin
          hi_d = acc_d;
          lo_d = lsr_d;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= OP_MULTU;
      cnt_q <= '0;
      acc_q <= '0;
      lsr_q <= '0;
      opb_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      dbz_q <= 1'b0;
    end else begin
      op_q  <= op_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      lsr_q <= lsr_d;
      opb_q <= opb_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      dbz_q <= dbz_d;
    end
  end

  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mul_div_seq.sv
// Scenario-task bench for mul_div_seq with a behavioural 32-bit ALU attached.
module tb_mul_div_seq;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  logic        clk, rst_n, start, op;
  logic [31:0] src_a, src_b, alu_a, alu_b, alu_result, hi, lo;
  logic [2:0]  alu_s;
  logic        alu_v, alu_z, busy, done, div_by_zero;

  int total = 0;
  int bad   = 0;
  exp_t exp_q[$];

  mul_div_seq #(.WIDTH(32), .ITER(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
    .alu_result(alu_result), .alu_v(alu_v), .alu_z(alu_z),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  // Behavioural ALU
  always_comb begin
    alu_result = (alu_s == 3'b100) ? (alu_a - alu_b) : (alu_a + alu_b);
    alu_z = (alu_result == 32'h0);
    alu_v = 1'b0;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one start pulse and queue the expected HI/LO result.
  task automatic issue(input logic o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [63:0] p;
    if (o == 1'b0) begin
      p = {32'h0, a} * {32'h0, b};
      e = '{hi: p[63:32], lo: p[31:0], dbz: 1'b0};
    end else if (b == 32'h0) begin
      e = '{hi: a, lo: 32'hFFFF_FFFF, dbz: 1'b1};
    end else begin
      e = '{hi: a % b, lo: a / b, dbz: 1'b0};
    end
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Count cycles after the accepting edge until done (bounded).
  task automatic wait_done(input logic [2:0] exp_sel, output int cyc,
                           output int busy_n, output int sel_bad, output bit seen);
    cyc = 0; busy_n = 0; sel_bad = 0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      cyc++;
      if (busy) busy_n++;
      if (done) seen = 1'b1;
      else if (alu_s !== exp_sel) sel_bad++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; op = 1'b0; src_a = '0; src_b = '0;
    #3;
    total++;
    if ({hi, lo, busy, done, div_by_zero} !== 67'h0) begin
      bad++; $display("FAIL reset_outputs got hi=%h lo=%h busy=%b done=%b dbz=%b want all zero",
                      hi, lo, busy, done, div_by_zero);
    end
    total++;
    if ({alu_a, alu_b, alu_s} !== {64'h0, 3'b010}) begin
      bad++; $display("FAIL reset_alu got a=%h b=%h s=%b want a=0 b=0 s=010", alu_a, alu_b, alu_s);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mul_max;
    int cyc, bn, sb; bit seen; exp_t e;
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(3'b010, cyc, bn, sb, seen);
    e = exp_q.pop_front();
    total++;
    if (cyc !== 33 || !seen) begin
      bad++; $display("FAIL mul_max_latency got %0d seen=%0d want 33", cyc, seen);
    end
    total++;
    if (bn !== 33) begin bad++; $display("FAIL mul_max_busy got %0d want 33", bn); end
    total++;
    if ({hi, lo, div_by_zero} !== e) begin
      bad++; $display("FAIL mul_max_result got hi=%h lo=%h want hi=%h lo=%h", hi, lo, e.hi, e.lo);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL mul_max_idle got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_mul_shift;
    int cyc, bn, sb; bit seen; exp_t e;
    issue(1'b0, 32'h1234_5678, 32'h0000_0010);
    wait_done(3'b010, cyc, bn, sb, seen);
    e = exp_q.pop_front();
    total++;
    if (sb !== 0 || !seen) begin
      bad++; $display("FAIL mul_select got %0d bad cycles seen=%0d want 0", sb, seen);
    end
    total++;
    if ({hi, lo, div_by_zero} !== e) begin
      bad++; $display("FAIL mul_shift_result got hi=%h lo=%h want hi=%h lo=%h", hi, lo, e.hi, e.lo);
    end
  endtask

  task automatic test_div;
    int cyc, bn, sb; bit seen; exp_t e;
    issue(1'b1, 32'd100, 32'd7);
    wait_done(3'b100, cyc, bn, sb, seen);
    e = exp_q.pop_front();
    total++;
    if (sb !== 0 || cyc !== 33) begin
      bad++; $display("FAIL div_select_latency got bad_sel=%0d cyc=%0d want 0 33", sb, cyc);
    end
    total++;
    if ({hi, lo, div_by_zero} !== e) begin
      bad++; $display("FAIL div_100_7 got hi=%h lo=%h want hi=%h lo=%h", hi, lo, e.hi, e.lo);
    end
    issue(1'b1, 32'hFFFF_FFFF, 32'h8000_0000);
    wait_done(3'b100, cyc, bn, sb, seen);
    e = exp_q.pop_front();
    total++;
    if ({hi, lo, div_by_zero} !== e || !seen) begin
      bad++; $display("FAIL div_big got hi=%h lo=%h want hi=%h lo=%h", hi, lo, e.hi, e.lo);
    end
  endtask

  task automatic test_div_by_zero;
    int cyc, bn, sb; bit seen; exp_t e;
    issue(1'b1, 32'h0000_1234, 32'h0);
    wait_done(3'b010, cyc, bn, sb, seen);
    e = exp_q.pop_front();
    total++;
    if (cyc !== 1 || !seen) begin
      bad++; $display("FAIL dbz_latency got %0d want 1", cyc);
    end
    total++;
    if ({hi, lo, div_by_zero} !== e) begin
      bad++; $display("FAIL dbz_result got hi=%h lo=%h dbz=%b want hi=%h lo=%h dbz=%b",
                      hi, lo, div_by_zero, e.hi, e.lo, e.dbz);
    end
    issue(1'b0, 32'd3, 32'd4);
    total++;
    if (div_by_zero !== 1'b0) begin
      bad++; $display("FAIL dbz_clear got %b want 0", div_by_zero);
    end
    wait_done(3'b010, cyc, bn, sb, seen);
    e = exp_q.pop_front();
    total++;
    if ({hi, lo, div_by_zero} !== e || !seen) begin
      bad++; $display("FAIL mul_3x4 got hi=%h lo=%h dbz=%b want hi=%h lo=%h", hi, lo, div_by_zero, e.hi, e.lo);
    end
  endtask

  task automatic test_ignore_start;
    int cyc, extra; bit seen; exp_t e;
    issue(1'b0, 32'h0000_1111, 32'h0002_2222);
    cyc = 0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        seen = 1'b1;
        start = 1'b1; op = 1'b0; src_a = 32'd7; src_b = 32'd9;
      end else if (cyc == 10) begin
        start = 1'b1; op = 1'b1; src_a = 32'hFF; src_b = 32'd3;
      end else begin
        start = 1'b0;
      end
    end
    @(posedge clk);
    #1 start = 1'b0;
    e = exp_q.pop_front();
    total++;
    if (cyc !== 33 || !seen) begin
      bad++; $display("FAIL ignore_latency got %0d want 33", cyc);
    end
    total++;
    if ({hi, lo, div_by_zero} !== e) begin
      bad++; $display("FAIL ignore_result got hi=%h lo=%h want hi=%h lo=%h", hi, lo, e.hi, e.lo);
    end
    extra = 0;
    repeat (3) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) extra++;
    end
    total++;
    if (extra !== 0) begin
      bad++; $display("FAIL ignore_no_restart got %0d busy cycles want 0", extra);
    end
  endtask

  task automatic test_reset_abort;
    int cyc, bn, sb; bit seen; exp_t e;
    issue(1'b0, 32'd5, 32'd6);
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    e = exp_q.pop_front();
    #1;
    total++;
    if ({hi, lo, busy, done} !== 66'h0) begin
      bad++; $display("FAIL abort_clear got hi=%h lo=%h busy=%b done=%b want all zero", hi, lo, busy, done);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL abort_no_done got %b want 0", done); end
    rst_n = 1'b1;
    @(negedge clk);
    issue(1'b0, 32'h0000_ABCD, 32'h0000_1234);
    wait_done(3'b010, cyc, bn, sb, seen);
    e = exp_q.pop_front();
    total++;
    if ({hi, lo, div_by_zero} !== e || cyc !== 33) begin
      bad++; $display("FAIL abort_restart got hi=%h lo=%h cyc=%0d want hi=%h lo=%h cyc=33",
                      hi, lo, cyc, e.hi, e.lo);
    end
  endtask

  initial begin
    test_reset();
    test_mul_max();
    test_mul_shift();
    test_div();
    test_div_by_zero();
    test_ignore_start();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
